// File: rtl/mdsa_pkg.sv
// Shared definitions for the sort-arbiter slice: FSM encoding, default frame
// width, the WAIT timeout limit and an index-width helper.
package mdsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    // Default frame width: N*N*DW with N=8, DW=32.
    localparam int FW = 2048;

    // Number of WAIT cycles tolerated without srt_oe when the timeout is built in.
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

    // Width of an index into n requesters (never below one bit).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mdsa_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Returns a one-hot grant, its index and an any flag.
module mdsa_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    import mdsa_pkg::*;

    logic          found_s;
    logic [IW-1:0] cand_s;

    // Walk the requesters starting at ptr and keep the first one found.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IW'((int'(ptr) + k) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                idx           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mdsa_sort_arbiter.sv
// Shares one matrix sorter between NREQ requesters. A round-robin pick loads
// the owner's frame into the sorter, waits for srt_oe, then holds the sorted
// frame for the owner until it is taken.
// Optional build macro MDSA_ARB_TIMEOUT_EN bounds the WAIT state; without it
// WAIT is unbounded and timeout_err is constant 0.
module mdsa_sort_arbiter #(
    parameter int NREQ = 4,
    parameter int N    = 8,
    parameter int DW   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*N*N*DW-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [N*N*DW-1:0]      rsp_data,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic                   srt_en,
    output logic                   srt_start,
    output logic [N*N*DW-1:0]      srt_data_in,
    input  logic                   srt_rdy,
    input  logic                   srt_oe,
    input  logic [N*N*DW-1:0]      srt_data_out,
    output logic                   busy,
    output logic                   timeout_err
);
    import mdsa_pkg::*;

    localparam int FRAME_W = N * N * DW;
    localparam int IW      = idx_width(NREQ);

    state_t               state_r;
    logic [IW-1:0]        ptr_r;
    logic [IW-1:0]        owner_r;
    logic [NREQ-1:0]      req_ready_r;
    logic [NREQ-1:0]      rsp_valid_r;
    logic [FRAME_W-1:0]   rsp_data_r;
    logic                 srt_en_r;
    logic                 srt_start_r;
    logic [FRAME_W-1:0]   srt_data_in_r;
    logic                 busy_r;

    logic [NREQ-1:0]      pick_grant_s;
    logic [IW-1:0]        pick_idx_s;
    logic                 pick_any_s;
    logic [IW-1:0]        ptr_next_s;
    logic [NREQ-1:0]      owner_oh_s;
    logic [FRAME_W-1:0]   sel_frame_s;

`ifdef MDSA_ARB_TIMEOUT_EN
    logic [7:0]           wait_cnt_r;
    logic                 timeout_err_r;
`endif

    mdsa_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Pointer after a grant: one past the winner, wrapping to 0.
    assign ptr_next_s = (pick_idx_s == IW'(NREQ - 1)) ? '0 : pick_idx_s + IW'(1);

    // Frame of the requester the picker currently selects.
    always_comb begin
        sel_frame_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx_s == IW'(i)) begin
                sel_frame_s = req_data[i*FRAME_W +: FRAME_W];
            end else begin
                sel_frame_s = sel_frame_s;
            end
        end
    end

    // One-hot form of the current owner, used for rsp_valid.
    always_comb begin
        owner_oh_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner_oh_s[i] = (owner_r == IW'(i));
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            owner_r       <= '0;
            req_ready_r   <= '0;
            rsp_valid_r   <= '0;
            rsp_data_r    <= '0;
            srt_en_r      <= 1'b0;
            srt_start_r   <= 1'b0;
            srt_data_in_r <= '0;
            busy_r        <= 1'b0;
`ifdef MDSA_ARB_TIMEOUT_EN
            wait_cnt_r    <= 8'd0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            req_ready_r <= '0;
            srt_start_r <= 1'b0;
`ifdef MDSA_ARB_TIMEOUT_EN
            timeout_err_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s && srt_rdy) begin
                        state_r       <= ST_LOAD;
                        owner_r       <= pick_idx_s;
                        ptr_r         <= ptr_next_s;
                        srt_data_in_r <= sel_frame_s;
                        req_ready_r   <= pick_grant_s;
                        srt_start_r   <= 1'b1;
                        srt_en_r      <= 1'b1;
                        busy_r        <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_r  <= ST_WAIT;
                    srt_en_r <= 1'b1;
`ifdef MDSA_ARB_TIMEOUT_EN
                    wait_cnt_r <= 8'd0;
`endif
                end
                ST_WAIT: begin
                    if (srt_oe) begin
                        state_r     <= ST_DELIVER;
                        rsp_data_r  <= srt_data_out;
                        rsp_valid_r <= owner_oh_s;
                        srt_en_r    <= 1'b0;
                    end else begin
`ifdef MDSA_ARB_TIMEOUT_EN
                        // ptr already points past the owner since the grant.
                        if (wait_cnt_r == (TIMEOUT_LIMIT - 8'd1)) begin
                            state_r       <= ST_IDLE;
                            timeout_err_r <= 1'b1;
                            srt_en_r      <= 1'b0;
                            busy_r        <= 1'b0;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + 8'd1;
                        end
`else
                        state_r <= ST_WAIT;
`endif
                    end
                end
                ST_DELIVER: begin
                    if (rsp_ready[owner_r]) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= '0;
                        busy_r      <= 1'b0;
                    end else begin
                        rsp_valid_r <= owner_oh_s;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= '0;
                    srt_en_r    <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign srt_en      = srt_en_r;
    assign srt_start   = srt_start_r;
    assign srt_data_in = srt_data_in_r;
    assign busy        = busy_r;
`ifdef MDSA_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_r;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdsa_sort_arbiter.sv
// Scoreboard bench for mdsa_sort_arbiter: random requesters and a behavioural
// sorter (returns the bitwise inverse of its input after a random latency),
// a round-robin reference model pushing expected results, and a monitor that
// pops and compares every delivered result. Directed tail covers srt_rdy
// gating, reset in WAIT and the WAIT timeout (MDSA_ARB_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_mdsa_sort_arbiter;
    localparam int NREQ = 4;
    localparam int N    = 8;
    localparam int DW   = 32;
    localparam int FW   = N * N * DW;
    localparam int STIM_STEPS = 3000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*FW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [FW-1:0]        rsp_data;
    logic [NREQ-1:0]      rsp_ready;
    logic                 srt_en;
    logic                 srt_start;
    logic [FW-1:0]        srt_data_in;
    logic                 srt_rdy;
    logic                 srt_oe;
    logic [FW-1:0]        srt_data_out;
    logic                 busy;
    logic                 timeout_err;

    always #5 clk = ~clk;

    mdsa_sort_arbiter #(.NREQ(NREQ), .N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .srt_en(srt_en), .srt_start(srt_start), .srt_data_in(srt_data_in),
        .srt_rdy(srt_rdy), .srt_oe(srt_oe), .srt_data_out(srt_data_out),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        int            owner;
        logic [FW-1:0] frame;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;
    bit   model_free = 1'b1;
    int   mptr     = 0;

    int            k;
    bit            seen;
    logic          acc;
    logic [FW-1:0] f1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual[63:0]=%0h required[63:0]=%0h", name, act[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int w = 0; w < FW / 32; w++) begin
            f[w*32 +: 32] = $urandom();
        end
        return f;
    endfunction

    // Reference round-robin: first pending requester at or after p, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int j = 0; j < NREQ; j++) begin
            if (v[(p + j) % NREQ]) return (p + j) % NREQ;
        end
        return -1;
    endfunction

    // Requesters, consumer, and reference model; pushes expected results on grant.
    task automatic run_stim();
        logic [NREQ-1:0] exp_ready = '0;
        int              exp_owner = -1;
        bit              hs_pending = 1'b0;
        int              step = 0;
        logic [FW-1:0]   frames [NREQ];
        exp_t            e;
        while (!done) begin
            @(negedge clk);
            step++;
            chk("req_ready", req_ready, exp_ready);
            chk("srt_start", srt_start, exp_ready != '0);
            if (exp_ready != '0) begin
                chk_frame("srt_data_in", srt_data_in, frames[exp_owner]);
                chk("srt_en_load", srt_en, 1);
                e.owner = exp_owner;
                e.frame = frames[exp_owner];
                exp_q.push_back(e);
                req_valid[exp_owner] = 1'b0;
            end
            if (hs_pending) model_free = 1'b1;
            hs_pending = 1'b0;
            chk("busy", busy, !model_free);
            if (rsp_valid != '0) begin
                if ($urandom_range(0, 3) == 0) begin
                    rsp_ready  = rsp_valid;
                    hs_pending = 1'b1;
                end else begin
                    rsp_ready = NREQ'($urandom()) & ~rsp_valid;
                end
            end else begin
                rsp_ready = NREQ'($urandom());
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i]) begin
                    if (step < STIM_STEPS && $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
                end else if (step < STIM_STEPS && $urandom_range(0, 3) == 0) begin
                    frames[i] = rand_frame();
                    req_data[i*FW +: FW] = frames[i];
                    req_valid[i] = 1'b1;
                end
            end
            srt_rdy = ($urandom_range(0, 3) != 0);
            exp_ready = '0;
            exp_owner = -1;
            if (model_free && srt_rdy && req_valid != '0) begin
                exp_owner = rr_pick(req_valid, mptr);
                exp_ready[exp_owner] = 1'b1;
                mptr = (exp_owner + 1) % NREQ;
                model_free = 1'b0;
            end
            if (step >= STIM_STEPS && req_valid == '0 && model_free && exp_q.size() == 0) begin
                done = 1'b1;
            end else if (step > STIM_STEPS + 5000) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout actual=busy required=drained");
                done = 1'b1;
            end
        end
    endtask

    // Behavioural sorter: ~input after 1..30 cycles; stray srt_oe when idle.
    task automatic run_sorter();
        bit            job = 1'b0;
        int            lat = 0;
        logic [FW-1:0] cap;
        while (!done) begin
            @(negedge clk);
            if (srt_start) begin
                job = 1'b1;
                cap = srt_data_in;
                lat = $urandom_range(1, 30);
                srt_oe = 1'b0;
                srt_data_out = rand_frame();
            end else if (job) begin
                chk("srt_en_wait", srt_en, 1);
                if (lat == 1) begin
                    srt_oe = 1'b1;
                    srt_data_out = ~cap;
                    job = 1'b0;
                end else begin
                    lat--;
                    srt_oe = 1'b0;
                    srt_data_out = rand_frame();
                end
            end else begin
                srt_oe = ($urandom_range(0, 7) == 0);
                srt_data_out = rand_frame();
            end
        end
        srt_oe = 1'b0;
    endtask

    // Monitor: pops an expected result whenever a delivery starts, checks it held.
    task automatic run_monitor();
        bit              in_dlv = 1'b0;
        exp_t            cur;
        logic [NREQ-1:0] oh;
        while (!done) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                if (!in_dlv) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected actual=%0h required=0", rsp_valid);
                    end else begin
                        cur = exp_q.pop_front();
                        in_dlv = 1'b1;
                    end
                end
                if (in_dlv) begin
                    oh = '0;
                    oh[cur.owner] = 1'b1;
                    chk("rsp_valid", rsp_valid, oh);
                    chk_frame("rsp_data", rsp_data, ~cur.frame);
                    chk("srt_en_dlv", srt_en, 0);
                end
            end else begin
                in_dlv = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = '0;
        srt_rdy = 1'b0; srt_oe = 1'b0; srt_data_out = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_srt_en", srt_en, 0);
        chk("rst_srt_start", srt_start, 0);
        chk("rst_timeout", timeout_err, 0);
        chk_frame("rst_rsp_data", rsp_data, '0);
        chk_frame("rst_srt_data_in", srt_data_in, '0);
        rst = 1'b0;

        fork
            run_stim();
            run_sorter();
            run_monitor();
        join
        chk("queue_empty", exp_q.size(), 0);
        req_valid = '0; rsp_ready = '0; srt_oe = 1'b0; srt_rdy = 1'b0;

        // srt_rdy low holds the arbiter in IDLE.
        f1 = rand_frame();
        req_data[1*FW +: FW] = f1;
        req_valid = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            chk("nordy_busy", busy, 0);
            chk("nordy_ready", req_ready, 0);
        end
        srt_rdy = 1'b1;
        @(negedge clk);
        chk("rdy_ready", req_ready, 4'b0010);
        chk("rdy_start", srt_start, 1);
        chk_frame("rdy_data_in", srt_data_in, f1);
        req_valid = '0;
        @(negedge clk);
        chk("wait_en", srt_en, 1);
        chk("wait_start", srt_start, 0);

        // Reset in WAIT, then a late srt_oe that must be ignored.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        srt_oe = 1'b1;
        srt_data_out = rand_frame();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_srt_en", srt_en, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk_frame("mid_rst_data_in", srt_data_in, '0);
        @(negedge clk);
        srt_oe = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_oe_rsp", rsp_valid, 0);
            chk("late_oe_busy", busy, 0);
        end
        // ptr back at 0: all requesting must grant requester 0.
        f1 = rand_frame();
        for (int i = 0; i < NREQ; i++) req_data[i*FW +: FW] = f1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("ptr_reset_grant", req_ready, 4'b0001);
        req_valid = '0;

`ifdef MDSA_ARB_TIMEOUT_EN
        k = 0;
        seen = 1'b0;
        while (k < 400 && !seen) begin
            @(negedge clk);
            k++;
            if (timeout_err) seen = 1'b1;
        end
        chk("timeout_cycle", k, 256);
        chk("timeout_busy", busy, 0);
        chk("timeout_rsp", rsp_valid, 0);
        @(negedge clk);
        chk("timeout_pulse", timeout_err, 0);
        req_valid = 4'b1111;
        @(negedge clk);
        chk("timeout_next_grant", req_ready, 4'b0010);
        req_valid = '0;
`else
        acc = 1'b0;
        repeat (300) begin
            @(negedge clk);
            acc = acc | timeout_err;
        end
        chk("no_timeout", acc, 0);
        chk("long_wait_busy", busy, 1);
        srt_oe = 1'b1;
        srt_data_out = ~f1;
        @(negedge clk);
        srt_oe = 1'b0;
        chk("long_wait_rsp", rsp_valid, 4'b0001);
        chk_frame("long_wait_data", rsp_data, ~f1);
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
        chk("long_wait_done", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdsa_sort_arbiter.md
MDSA_SORT_ARBITER -- requirements
Module: mdsa_sort_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one sorter.
REQ-002 SHALL have parameter N, default 8: matrix dimension.
REQ-003 SHALL have parameter DW, default 32: element width; frame width FW = N*N*DW = 2048.
REQ-004 SHALL have ports clk (in, 1: the single clock) and rst (in, 1: reset, synchronous, active-high).
REQ-005 SHALL have ports req_valid (in, NREQ: request pending) and req_data (in, NREQ*FW: requester i frame at slice i).
REQ-006 SHALL have port req_ready (out, NREQ): one-cycle accept pulse to the owner.
REQ-007 SHALL have ports rsp_valid (out, NREQ: one-hot result valid), rsp_data (out, FW: sorted frame) and rsp_ready (in, NREQ: result taken).
REQ-008 SHALL have ports srt_en (out, 1), srt_start (out, 1) and srt_data_in (out, FW) driving the sorter.
REQ-009 SHALL have ports srt_rdy (in, 1), srt_oe (in, 1) and srt_data_out (in, FW) from the sorter.
REQ-010 SHALL have ports busy (out, 1: state not IDLE) and timeout_err (out, 1: error pulse).

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, WAIT and DELIVER.
REQ-012 IDLE: SHALL move to LOAD when any req_valid=1 and srt_rdy=1, latching owner = round-robin pick and req_data[owner] into srt_data_in on that edge; otherwise stay in IDLE.
REQ-013 Round-robin: search SHALL start at pointer ptr; after a grant to i, ptr SHALL become (i+1) mod NREQ.
REQ-014 LOAD lasts exactly one cycle, with srt_start=1, srt_en=1 and req_ready[owner]=1; SHALL then go to WAIT.
REQ-015 WAIT: srt_en SHALL be 1; on srt_oe=1 the FSM SHALL capture srt_data_out into rsp_data and go to DELIVER.
REQ-016 DELIVER: rsp_valid[owner] SHALL be held at 1 and srt_en at 0 until rsp_ready[owner]=1, then go to IDLE; rsp_ready on non-owner bits SHALL be ignored.
REQ-017 srt_oe outside WAIT SHALL be ignored; srt_start SHALL never be 1 outside LOAD.
REQ-018 Requesters SHALL hold req_valid and req_data stable until req_ready; a requester that drops req_valid before grant is simply not picked.
REQ-019 Latency: minimum request to srt_start SHALL be 1 cycle; a back-to-back grant SHALL be possible on the cycle after rsp_ready.
REQ-020 srt_data_in and rsp_data SHALL hold their values between loads.

Reset
REQ-021 On rst=1 at a clk edge, including mid-operation, the block SHALL set state=IDLE, ptr=0, owner=0, and all outputs including data registers to 0; any in-flight sort result SHALL be discarded.

Configuration
REQ-022 Macro MDSA_ARB_TIMEOUT_EN, when defined, SHALL add an 8-bit WAIT counter (cleared on entering WAIT); at 255 cycles without srt_oe, timeout_err SHALL pulse for 1 cycle, state SHALL go to IDLE with no rsp_valid, and ptr SHALL advance past owner.
REQ-023 Without MDSA_ARB_TIMEOUT_EN, WAIT SHALL be unbounded and timeout_err SHALL be tied to 0.

Structure
REQ-024 Package mdsa_pkg SHALL hold the state encoding, the FW localparam and the timeout limit constant.
REQ-025 The round-robin picker SHALL be a sub-module mdsa_rr_pick (req vector and ptr in, one-hot grant and index out, combinational).

Verification
REQ-026 Single request: req_valid=0001, sorter returns srt_oe 20 cycles after start -> srt_start 1 cycle after request, rsp_valid=0001 with rsp_data equal to srt_data_out.
REQ-027 All requesters valid continuously -> grant order 0,1,2,3,0 with exactly one req_ready pulse per grant.
REQ-028 srt_rdy=0 with req_valid=0010 -> stays IDLE and busy=0; srt_rdy rises -> LOAD on the next cycle.
REQ-029 rsp_ready withheld 10 cycles, with a non-owner rsp_ready pulse in between -> rsp_valid held, FSM stays in DELIVER.
REQ-030 rst asserted in WAIT -> next cycle all outputs 0 and ptr=0; a late srt_oe is ignored.
REQ-031 With MDSA_ARB_TIMEOUT_EN and no srt_oe -> timeout_err pulse after 255 WAIT cycles, then IDLE; the next grant goes to owner+1.
